// File: rtl/mdu_pkg.sv
// Shared encodings, FSM state constants and sizing helpers for the multiply/divide unit.
// Optional multiply-accumulate support is enabled by defining MDU_MADD_EN.
package mdu_pkg;

    typedef logic [2:0] mdop_t;

    localparam mdop_t MDOP_MULT  = 3'd0;
    localparam mdop_t MDOP_MULTU = 3'd1;
    localparam mdop_t MDOP_DIV   = 3'd2;
    localparam mdop_t MDOP_DIVU  = 3'd3;
    localparam mdop_t MDOP_MTHI  = 3'd4;
    localparam mdop_t MDOP_MTLO  = 3'd5;
    localparam mdop_t MDOP_MADD  = 3'd6;
    localparam mdop_t MDOP_MADDU = 3'd7;

    typedef logic [0:0] state_t;

    localparam state_t S_IDLE = 1'b0;
    localparam state_t S_RUN  = 1'b1;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // Down-counter must hold the larger of the two latencies.
    function automatic int unsigned cnt_width(input int unsigned m, input int unsigned d);
        int unsigned mx;
        mx = (m > d) ? m : d;
        return $clog2(mx + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(MULT_CYCLES_DEF, DIV_CYCLES_DEF);

    // Ops that occupy the unit for more than the issuing cycle.
    function automatic logic is_multi(input mdop_t op);
        logic r;
        r = (op == MDOP_MULT) || (op == MDOP_MULTU) || (op == MDOP_DIV) || (op == MDOP_DIVU);
`ifdef MDU_MADD_EN
        r = r || (op == MDOP_MADD) || (op == MDOP_MADDU);
`endif
        return r;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-stage request/response bundle between the pipeline and the multiply/divide unit.
interface mdu_if;
    import mdu_pkg::*;

    logic        start;
    mdop_t       mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, mdop, a, b, input busy, stall, hi, lo);
    modport slave  (input start, mdop, a, b, output busy, stall, hi, lo);

endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy/stall freeze the front end while in flight.
// Define MDU_MADD_EN to enable madd/maddu; otherwise those opcodes are ignored.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     reset,
    mdu_if.slave     bus
);

    localparam int unsigned CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    mdop_t         op_q, op_n;
    logic [31:0]   a_q, a_n, b_q, b_n;
    logic [31:0]   hi_q, hi_n, lo_q, lo_n;
    logic          busy_q, busy_n;
    logic [63:0]   result;

    // Result datapath, evaluated on the latched operands.
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_mag_safe, q_mag, r_mag, quo_s, rem_s;
    logic [31:0] b_safe;

    always_comb begin
        prod_s     = 64'($signed(a_q)) * 64'($signed(b_q));
        prod_u     = 64'(a_q) * 64'(b_q);
        a_mag      = a_q[31] ? (~a_q + 32'd1) : a_q;
        b_mag      = b_q[31] ? (~b_q + 32'd1) : b_q;
        b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        b_safe     = (b_q == 32'd0) ? 32'd1 : b_q;
        q_mag      = a_mag / b_mag_safe;
        r_mag      = a_mag % b_mag_safe;
        // Magnitude divide also yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
        quo_s      = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
        rem_s      = a_q[31] ? (~r_mag + 32'd1) : r_mag;

        case (op_q)
            MDOP_MULT:  result = prod_s;
            MDOP_MULTU: result = prod_u;
            MDOP_DIV:   result = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {rem_s, quo_s};
            MDOP_DIVU:  result = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF}
                                                : {a_q % b_safe, a_q / b_safe};
`ifdef MDU_MADD_EN
            MDOP_MADD:  result = {hi_q, lo_q} + prod_s;
            MDOP_MADDU: result = {hi_q, lo_q} + prod_u;
`endif
            default:    result = {hi_q, lo_q};
        endcase
    end

    // Next-state and register-update logic.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        op_n    = op_q;
        a_n     = a_q;
        b_n     = b_q;
        hi_n    = hi_q;
        lo_n    = lo_q;
        busy_n  = busy_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.mdop)
                        MDOP_MULT, MDOP_MULTU,
`ifdef MDU_MADD_EN
                        MDOP_MADD, MDOP_MADDU,
`endif
                        MDOP_DIV, MDOP_DIVU: begin
                            op_n    = bus.mdop;
                            a_n     = bus.a;
                            b_n     = bus.b;
                            busy_n  = 1'b1;
                            state_n = S_RUN;
                            cnt_n   = (bus.mdop == MDOP_DIV || bus.mdop == MDOP_DIVU)
                                      ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        end
                        MDOP_MTHI: hi_n = bus.a;
                        MDOP_MTLO: lo_n = bus.a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_n = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    {hi_n, lo_n} = result;
                    busy_n       = 1'b0;
                    state_n      = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= MDOP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            op_q    <= op_n;
            a_q     <= a_n;
            b_q     <= b_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            busy_q  <= busy_n;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.stall = busy_q | (bus.start & is_multi(bus.mdop));

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO and busy length, a monitor checks on completion.
module tb_mult_div_unit;
    import mdu_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic clk;
    logic reset;
    mdu_if bus ();

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic push_exp(input string nm, input logic [31:0] h, input logic [31:0] l, input int c);
        exp_t e;
        e.name = nm; e.hi = h; e.lo = l; e.cycles = c;
        sb.push_back(e);
    endtask

    // Drive one request for a single clock edge and check the combinational stall.
    task automatic issue(input string nm, input mdop_t op, input logic [31:0] av,
                         input logic [31:0] bv, input logic exp_stall);
        @(negedge clk);
        bus.start = 1'b1; bus.mdop = op; bus.a = av; bus.b = bv;
        #1 chk({nm, "_stall"}, 32'(bus.stall), 32'(exp_stall));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || sb.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            total++;
            $display("FAIL wait_idle: busy=%0d pending=%0d after %0d cycles", bus.busy, sb.size(), n);
        end
        @(negedge clk);
    endtask

    // Monitor: on each busy fall, compare HI/LO and the busy length against the scoreboard.
    initial begin
        int   cyc = 0;
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                cyc  = 0;
                prev = 1'b0;
            end else begin
                if (bus.busy) cyc++;
                else if (prev) begin
                    if (sb.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_done: got completion expected none");
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_hi"}, bus.hi, e.hi);
                        chk({e.name, "_lo"}, bus.lo, e.lo);
                        chk({e.name, "_cycles"}, 32'(cyc), 32'(e.cycles));
                    end
                    cyc = 0;
                end
                prev = bus.busy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.mdop = MDOP_MULT; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        reset = 1'b0;

        push_exp("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue("mult", MDOP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
        wait_idle();

        push_exp("divu", 32'd2, 32'd14, 10);
        issue("divu", MDOP_DIVU, 32'd100, 32'd7, 1'b1);
        wait_idle();

        push_exp("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue("div_neg", MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle();

        push_exp("div_zero", 32'd5, 32'hFFFF_FFFF, 10);
        issue("div_zero", MDOP_DIV, 32'd5, 32'd0, 1'b1);
        wait_idle();

        push_exp("div_ovf", 32'd0, 32'h8000_0000, 10);
        issue("div_ovf", MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle();

        push_exp("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 5);
        issue("multu_max", MDOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_idle();

        issue("mthi", MDOP_MTHI, 32'h0000_1234, 32'd0, 1'b0);
        chk("mthi_hi", bus.hi, 32'h0000_1234);
        chk("mthi_lo_kept", bus.lo, 32'h0000_0001);
        chk("mthi_busy", 32'(bus.busy), 32'd0);
        issue("mtlo", MDOP_MTLO, 32'h0000_ABCD, 32'd0, 1'b0);
        chk("mtlo_lo", bus.lo, 32'h0000_ABCD);

        // Requests issued while busy must be dropped.
        push_exp("multu_busy", 32'd1, 32'd0, 5);
        issue("multu_busy", MDOP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1);
        issue("mtlo_busy", MDOP_MTLO, 32'd9, 32'd0, 1'b1);
        chk("mtlo_busy_lo", bus.lo, 32'h0000_ABCD);
        chk("mtlo_busy_stall", 32'(bus.stall), 32'd1);
        issue("mult_busy", MDOP_MULT, 32'd7, 32'd7, 1'b1);
        wait_idle();

        // Reset during a divide aborts it with no later write.
        issue("div_abort", MDOP_DIV, 32'd100, 32'd3, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_nowrite_hi", bus.hi, 32'd0);
        chk("abort_nowrite_lo", bus.lo, 32'd0);
        chk("abort_nowrite_busy", 32'(bus.busy), 32'd0);
        push_exp("mult_after_rst", 32'd0, 32'd12, 5);
        issue("mult_after_rst", MDOP_MULT, 32'd3, 32'd4, 1'b1);
        wait_idle();

        issue("mthi0", MDOP_MTHI, 32'd0, 32'd0, 1'b0);
        issue("mtlo_ones", MDOP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
        push_exp("maddu", 32'd1, 32'd0, 5);
        issue("maddu", MDOP_MADDU, 32'd1, 32'd1, 1'b1);
        wait_idle();
        push_exp("madd", 32'd0, 32'hFFFF_FFFF, 5);
        issue("madd", MDOP_MADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_idle();
`else
        issue("maddu_off", MDOP_MADDU, 32'd1, 32'd1, 1'b0);
        repeat (3) @(negedge clk);
        chk("maddu_off_busy", 32'(bus.busy), 32'd0);
        chk("maddu_off_hi", bus.hi, 32'd0);
        chk("maddu_off_lo", bus.lo, 32'hFFFF_FFFF);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
